// File: rtl/arcade_clk_pkg.sv
// arcade_clk_pkg
//   Shared defaults and helpers for the arcade clock-enable / core-reset
//   controller.
//   - DEF_NUM_CE / DEF_ACC_W / DEF_RST_HOLD : default parameter values
//   - cnt_width()  : bits needed to hold a hold count of 0..max_val
//   - ch_lsb()     : LSB of channel ch inside a packed per-channel bus
//   - ce_act_e     : which update a fractional channel performs this cycle
package arcade_clk_pkg;

  localparam int unsigned DEF_NUM_CE   = 3;
  localparam int unsigned DEF_ACC_W    = 16;
  localparam int unsigned DEF_RST_HOLD = 16;

  // Width of a down-counter that must hold max_val; never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Channel ch occupies [ch*w +: w] of the packed num/den buses.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,  // paused or den==0: phase frozen, no enable
    ACT_STEP  = 2'd1,  // acc += num, no enable
    ACT_WRAP  = 2'd2,  // acc += num - den, enable
    ACT_CLEAR = 2'd3   // phase out of range or num>den: acc = 0, enable
  } ce_act_e;

endpackage

// File: rtl/arcade_frac_ce.sv
// arcade_frac_ce
//   One fractional clock-enable channel. A num/den phase accumulator emits
//   exactly num enables per den clocks over the long run, with no drift.
//   Ports:
//     clk_i    system clock, rising edge
//     reset_i  synchronous active-high reset (acc=0, ce=0)
//     pause_i  freezes the phase and forces ce low
//     num_i    numerator (rate = num/den)
//     den_i    denominator; 0 disables the channel
//     ce_o     registered single-cycle enable
module arcade_frac_ce
  import arcade_clk_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pause_i,
  input  logic [ACC_W-1:0] num_i,
  input  logic [ACC_W-1:0] den_i,
  output logic             ce_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  ce_act_e          act;

  always_comb begin
    // One extra bit so acc+num never wraps before the compare with den.
    sum   = {1'b0, acc_q} + {1'b0, num_i};
    act   = ACT_STEP;
    acc_d = acc_q;
    ce_d  = 1'b0;

    if (pause_i || (den_i == '0)) begin
      act = ACT_HOLD;
    end else if ((acc_q >= den_i) || (num_i > den_i)) begin
      // acc >= den only happens when den shrank at runtime; restart phase.
      // num > den saturates at one enable per cycle.
      act = ACT_CLEAR;
    end else if (sum >= {1'b0, den_i}) begin
      act = ACT_WRAP;
    end else begin
      act = ACT_STEP;
    end

    case (act)
      ACT_CLEAR: begin
        acc_d = '0;
        ce_d  = 1'b1;
      end
      ACT_WRAP: begin
        acc_d = ACC_W'(sum - {1'b0, den_i});
        ce_d  = 1'b1;
      end
      ACT_STEP: begin
        acc_d = sum[ACC_W-1:0];
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/arcade_clk_ctrl.sv
// arcade_clk_ctrl
//   Clock-enable and core-reset controller for the arcade top levels.
//   NUM_CE fractional enables are generated from clk_sys; the game core is
//   held in reset while a ROM download runs, before the first download has
//   completed, or while the user asks for a reset, and for RST_HOLD cycles
//   after the last request clears.
//   Ports:
//     clk_sys      system clock, rising edge
//     reset        synchronous active-high module reset (PLL not locked)
//     soft_reset   user reset request, level
//     ioctl_downl  ROM download in progress, level
//     pause        freezes all enables (one-cycle latency in and out)
//     ce_num       per-channel numerators, channel i at [i*ACC_W +: ACC_W]
//     ce_den       per-channel denominators, same packing
//     ce           registered single-cycle enables
//     core_reset   registered reset to the game core
//     rom_loaded   sticky: a download has completed since power-up
module arcade_clk_ctrl
  import arcade_clk_pkg::*;
#(
  parameter int unsigned NUM_CE   = DEF_NUM_CE,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned RST_HOLD = DEF_RST_HOLD
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    soft_reset,
  input  logic                    ioctl_downl,
  input  logic                    pause,
  input  logic [NUM_CE*ACC_W-1:0] ce_num,
  input  logic [NUM_CE*ACC_W-1:0] ce_den,
  output logic [NUM_CE-1:0]       ce,
  output logic                    core_reset
  ,
  output logic                    rom_loaded
);

  localparam int unsigned CNT_W = cnt_width(RST_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD);

  // Enables keep running while core_reset is high: the core needs them
  // to clock through its own reset.
  for (genvar g = 0; g < NUM_CE; g++) begin : g_ch
    arcade_frac_ce #(
      .ACC_W (ACC_W)
    ) u_ce (
      .clk_i   (clk_sys),
      .reset_i (reset),
      .pause_i (pause),
      .num_i   (ce_num[ch_lsb(g, ACC_W) +: ACC_W]),
      .den_i   (ce_den[ch_lsb(g, ACC_W) +: ACC_W]),
      .ce_o    (ce[g])
    );
  end

  logic             downl_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_reset_q, core_reset_d;
  logic             rom_loaded_d;
  logic             req;
  // Power-up value only; module reset leaves it alone so ROM contents
  // survive a PLL relock.
  logic             rom_loaded_q = 1'b0;

  always_comb begin
    // downl_d is cleared by reset, so a download already low at release
    // does not count as a completed download.
    rom_loaded_d = rom_loaded_q | (downl_d_q & ~ioctl_downl);
    req          = soft_reset | ioctl_downl | ~rom_loaded_d;
    cnt_d        = cnt_q;
    core_reset_d = 1'b0;
    if (req) begin
      cnt_d        = HOLD_LOAD;
      core_reset_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d        = cnt_q - CNT_W'(1);
      core_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      downl_d_q    <= 1'b0;
      cnt_q        <= HOLD_LOAD;
      core_reset_q <= 1'b1;
    end else begin
      downl_d_q    <= ioctl_downl;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      rom_loaded_q <= rom_loaded_d;
    end
  end

  assign core_reset = core_reset_q;
  assign rom_loaded = rom_loaded_q;

endmodule

// File: tb/tb_arcade_clk_ctrl.sv
module tb_arcade_clk_ctrl;

  localparam int NUM_CE   = 3;
  localparam int ACC_W    = 16;
  localparam int RST_HOLD = 16;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #21 clk_sys = ~clk_sys;

  logic reset       = 1'b1;
  logic soft_reset  = 1'b0;
  logic ioctl_downl = 1'b0;
  logic pause       = 1'b0;
  logic [ACC_W-1:0] num_v [NUM_CE];
  logic [ACC_W-1:0] den_v [NUM_CE];
  logic [NUM_CE*ACC_W-1:0] ce_num, ce_den;
  logic [NUM_CE-1:0] ce;
  logic core_reset, rom_loaded;

  assign ce_num = {num_v[2], num_v[1], num_v[0]};
  assign ce_den = {den_v[2], den_v[1], den_v[0]};

  arcade_clk_ctrl #(
    .NUM_CE   (NUM_CE),
    .ACC_W    (ACC_W),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .ioctl_downl (ioctl_downl),
    .pause       (pause),
    .ce_num      (ce_num),
    .ce_den      (ce_den),
    .ce          (ce),
    .core_reset  (core_reset),
    .rom_loaded  (rom_loaded)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] edge_cnt = 32'd0;
  always @(posedge clk_sys) edge_cnt <= edge_cnt + 32'd1;

  logic [31:0] exp_ce0_q[$];
  logic [31:0] exp_ce1_q[$];
  logic [31:0] exp_ce2_q[$];
  logic [32:0] exp_cr_q[$];   // {value, edge at which it takes effect}
  logic [32:0] exp_rom_q[$];

  int n_checks = 0;
  int n_errors = 0;

  longint kk [NUM_CE];        // enabled steps since phase 0, per channel
  logic   force_wrap [NUM_CE];

  logic        cr_want  = 1'b1;
  logic        rom_want = 1'b0;
  int          ch2_cnt  = 0;
  int          tot_cnt  = 0;
  logic        gap_en   = 1'b0;
  logic [31:0] last2    = 32'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, edge_cnt, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_ce(input int ch, input logic got);
    logic want;
    want = 1'b0;
    case (ch)
      0: if (exp_ce0_q.size() != 0 && exp_ce0_q[0] == edge_cnt) begin void'(exp_ce0_q.pop_front()); want = 1'b1; end
      1: if (exp_ce1_q.size() != 0 && exp_ce1_q[0] == edge_cnt) begin void'(exp_ce1_q.pop_front()); want = 1'b1; end
      default: if (exp_ce2_q.size() != 0 && exp_ce2_q[0] == edge_cnt) begin void'(exp_ce2_q.pop_front()); want = 1'b1; end
    endcase
    check($sformatf("ce%0d", ch), {31'd0, got}, {31'd0, want});
  endtask

  always @(negedge clk_sys) begin
    logic [32:0] e;
    mon_ce(0, ce[0]);
    mon_ce(1, ce[1]);
    mon_ce(2, ce[2]);
    tot_cnt += $countones(ce);
    if (ce[2]) begin
      ch2_cnt++;
      if (gap_en) check("ch2_gap_le_14", {31'd0, ((edge_cnt - last2) <= 32'd14)}, 32'd1);
      last2 = edge_cnt;
    end
    if (exp_cr_q.size() != 0) begin
      e = exp_cr_q[0];
      if (e[31:0] == edge_cnt) begin cr_want = e[32]; void'(exp_cr_q.pop_front()); end
    end
    check("core_reset", {31'd0, core_reset}, {31'd0, cr_want});
    if (exp_rom_q.size() != 0) begin
      e = exp_rom_q[0];
      if (e[31:0] == edge_cnt) begin rom_want = e[32]; void'(exp_rom_q.pop_front()); end
    end
    check("rom_loaded", {31'd0, rom_loaded}, {31'd0, rom_want});
  end

  // ---------------- driver tasks ----------------
  task automatic push_ce(input int ch, input logic [31:0] ed);
    case (ch)
      0: exp_ce0_q.push_back(ed);
      1: exp_ce1_q.push_back(ed);
      default: exp_ce2_q.push_back(ed);
    endcase
  endtask

  // Predict the coming edge from the closed form: a pulse on step k iff
  // floor(k*num/den) advances. Then clock it and wait for the monitor.
  task automatic tick();
    logic [31:0] nxt;
    nxt = edge_cnt + 32'd1;
    for (int ch = 0; ch < NUM_CE; ch++) begin
      if (reset) begin
        kk[ch] = 0;
        force_wrap[ch] = 1'b0;
      end else if (!pause && force_wrap[ch]) begin
        push_ce(ch, nxt);
        kk[ch] = 0;
        force_wrap[ch] = 1'b0;
      end else if (!pause && den_v[ch] != '0) begin
        kk[ch]++;
        if ((longint'(num_v[ch]) * kk[ch]) / longint'(den_v[ch]) !=
            (longint'(num_v[ch]) * (kk[ch] - 1)) / longint'(den_v[ch]))
          push_ce(ch, nxt);
      end
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int ch = 0; ch < NUM_CE; ch++) begin
      kk[ch] = 0;
      force_wrap[ch] = 1'b0;
    end
    num_v[0] = 16'd1;   den_v[0] = 16'd4;
    num_v[1] = 16'd1;   den_v[1] = 16'd6;
    num_v[2] = 16'd179; den_v[2] = 16'd2400;

    // Power-up reset.
    tick();
    check("rst_ce", {29'd0, ce}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    ticks(2);

    // Release; download for 100 edges, then run a full 2400-cycle window.
    reset = 1'b0;
    ch2_cnt = 0;
    last2 = edge_cnt;
    gap_en = 1'b1;
    for (int i = 1; i <= 2400; i++) begin
      ioctl_downl = (i <= 100);
      if (i == 101) begin
        exp_rom_q.push_back({1'b1, edge_cnt + 32'd1});
        exp_cr_q.push_back({1'b0, edge_cnt + 32'd1 + 32'(RST_HOLD)});
      end
      tick();
    end
    gap_en = 1'b0;
    check("ch2_count_2400", ch2_cnt, 179);

    // Pause for 50 edges: no enables at all.
    ticks(7);
    pause = 1'b1;
    tot_cnt = 0;
    ticks(50);
    check("pause_no_pulses", tot_cnt, 0);
    pause = 1'b0;
    ch2_cnt = 0;
    ticks(2400);
    check("ch2_count_after_pause", ch2_cnt, 179);

    // Runtime den change 6->2 with acc=5 on channel 1.
    for (int g = 0; g < 8 && (kk[1] % 6) != 5; g++) tick();
    check("ch1_phase_5", 32'(kk[1] % 6), 32'd5);
    den_v[1] = 16'd2;
    force_wrap[1] = 1'b1;
    ticks(10);

    // num > den on channel 0: enable every cycle and acc left at 0.
    num_v[0] = 16'd5; den_v[0] = 16'd3;
    ticks(6);
    num_v[0] = 16'd1; den_v[0] = 16'd4;
    kk[0] = 0;
    ticks(10);

    // Single-cycle soft reset.
    soft_reset = 1'b1;
    exp_cr_q.push_back({1'b1, edge_cnt + 32'd1});
    tick();
    soft_reset = 1'b0;
    exp_cr_q.push_back({1'b0, edge_cnt + 32'd1 + 32'(RST_HOLD)});
    ticks(25);

    // Second pulse during the hold restarts the count.
    soft_reset = 1'b1;
    exp_cr_q.push_back({1'b1, edge_cnt + 32'd1});
    tick();
    soft_reset = 1'b0;
    ticks(5);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    exp_cr_q.push_back({1'b0, edge_cnt + 32'd1 + 32'(RST_HOLD)});
    ticks(25);

    // Module reset after load; channel 2 disabled with den=0.
    den_v[2] = 16'd0;
    reset = 1'b1;
    exp_cr_q.push_back({1'b1, edge_cnt + 32'd1});
    tick();
    check("reset_keeps_rom_loaded", {31'd0, rom_loaded}, 32'd1);
    check("reset_ce_low", {29'd0, ce}, 32'd0);
    tick();
    reset = 1'b0;
    exp_cr_q.push_back({1'b0, edge_cnt + 32'd1 + 32'(RST_HOLD)});
    ticks(60);

    check("ce0_q_drained", exp_ce0_q.size(), 0);
    check("ce1_q_drained", exp_ce1_q.size(), 0);
    check("ce2_q_drained", exp_ce2_q.size(), 0);
    check("cr_q_drained", exp_cr_q.size(), 0);
    check("rom_q_drained", exp_rom_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
